// File: rtl/sys_mem_arb.sv
// sys_mem_arb
//   Round-robin arbiter sharing the system memory controller port between
//   NUM_AGENTS requesters. The granted command goes through a one-entry
//   output register that honours cntrlr_rdy. Reads are tagged with the
//   requester ID in an in-order tag FIFO so that returned data can be
//   steered back to the agent that asked for it.
//
// Ports
//   clk, rst_n        cortex clock, asynchronous active-low reset
//   agent_wren/rden   per-agent write/read request (write wins if both set)
//   agent_addr/wdata  packed per-agent address / write data
//   agent_wait        0 = that agent's request is accepted this cycle
//   agent_rd_valid    one-hot read-data strobe to the owning agent
//   agent_rdata       shared read data, qualified by agent_rd_valid
//   cntrlr_*          command/response interface to the memory controller
//   rd_pend_cnt       number of outstanding reads
//   err_unexp_rd      sticky: read data returned with no read pending
module sys_mem_arb #(
  parameter int unsigned NUM_AGENTS  = 2,
  parameter int unsigned MEM_DATA_W  = 32,
  parameter int unsigned MEM_ADDR_W  = 27,
  parameter int unsigned MAX_RD_PEND = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_AGENTS-1:0]            agent_wren,
  input  logic [NUM_AGENTS-1:0]            agent_rden,
  input  logic [NUM_AGENTS*MEM_ADDR_W-1:0] agent_addr,
  input  logic [NUM_AGENTS*MEM_DATA_W-1:0] agent_wdata,
  output logic [NUM_AGENTS-1:0]            agent_wait,
  output logic [NUM_AGENTS-1:0]            agent_rd_valid,
  output logic [MEM_DATA_W-1:0]            agent_rdata,
  input  logic                             cntrlr_rdy,
  output logic                             cntrlr_wren,
  output logic                             cntrlr_rden,
  output logic [MEM_ADDR_W-1:0]            cntrlr_addr,
  output logic [MEM_DATA_W-1:0]            cntrlr_wdata,
  input  logic                             cntrlr_rd_valid,
  input  logic [MEM_DATA_W-1:0]            cntrlr_rdata,
  output logic [$clog2(MAX_RD_PEND):0]     rd_pend_cnt,
  output logic                             err_unexp_rd
);

  localparam int unsigned ID_W  = $clog2(NUM_AGENTS);
  localparam int unsigned PTR_W = $clog2(MAX_RD_PEND);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ID_W-1:0]       rr_ptr;
  logic [ID_W-1:0]       cand;
  logic                  cand_vld;
  logic                  cand_wr;
  logic                  cmd_vld;
  logic                  slot_free;
  logic                  fifo_full;
  logic                  accept;
  logic                  push;
  logic                  pop;
  logic [NUM_AGENTS-1:0] req_act;

  logic [ID_W-1:0]       tag_mem [MAX_RD_PEND];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;

  assign req_act = agent_wren | agent_rden;

  // First active agent at or after rr_ptr, wrapping around.
  always_comb begin
    int unsigned idx;
    cand     = '0;
    cand_vld = 1'b0;
    idx      = 0;
    for (int unsigned k = 0; k < NUM_AGENTS; k++) begin
      idx = (32'(rr_ptr) + k) % NUM_AGENTS;
      if (!cand_vld && req_act[ID_W'(idx)]) begin
        cand_vld = 1'b1;
        cand     = ID_W'(idx);
      end
    end
  end

  assign cand_wr   = agent_wren[cand];
  assign cmd_vld   = cntrlr_wren | cntrlr_rden;
  assign slot_free = ~cmd_vld | cntrlr_rdy;
  // Registered count only: a pop in this same cycle does not open a slot.
  assign fifo_full = (rd_pend_cnt >= CNT_W'(MAX_RD_PEND));
  // A read blocked on a full FIFO stalls arbitration; no skip to later agents.
  assign accept    = cand_vld & slot_free & (cand_wr | ~fifo_full);
  assign push      = accept & ~cand_wr;
  assign pop       = cntrlr_rd_valid & (rd_pend_cnt != '0);

  always_comb begin
    agent_wait = '1;
    if (accept) begin
      agent_wait[cand] = 1'b0;
    end
  end

  // Output command register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cntrlr_wren  <= 1'b0;
      cntrlr_rden  <= 1'b0;
      cntrlr_addr  <= '0;
      cntrlr_wdata <= '0;
    end else if (accept) begin
      cntrlr_wren  <= cand_wr;
      cntrlr_rden  <= ~cand_wr;
      cntrlr_addr  <= agent_addr[32'(cand)*MEM_ADDR_W +: MEM_ADDR_W];
      cntrlr_wdata <= agent_wdata[32'(cand)*MEM_DATA_W +: MEM_DATA_W];
    end else if (cntrlr_rdy) begin
      cntrlr_wren  <= 1'b0;
      cntrlr_rden  <= 1'b0;
    end
  end

  // Round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= (cand == ID_W'(NUM_AGENTS - 1)) ? '0 : cand + ID_W'(1);
    end
  end

  // Tag FIFO storage; contents are don't-care while pointers say empty.
  always_ff @(posedge clk) begin
    if (push) begin
      tag_mem[wr_ptr] <= cand;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      rd_pend_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   rd_pend_cnt <= rd_pend_cnt + CNT_W'(1);
        2'b01:   rd_pend_cnt <= rd_pend_cnt - CNT_W'(1);
        default: rd_pend_cnt <= rd_pend_cnt;
      endcase
    end
  end

  // Read return steering, one cycle after cntrlr_rd_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      agent_rd_valid <= '0;
      agent_rdata    <= '0;
      err_unexp_rd   <= 1'b0;
    end else begin
      agent_rd_valid <= '0;
      if (pop) begin
        agent_rd_valid <= NUM_AGENTS'(1) << tag_mem[rd_ptr];
        agent_rdata    <= cntrlr_rdata;
      end
      if (cntrlr_rd_valid && (rd_pend_cnt == '0)) begin
        err_unexp_rd <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sys_mem_arb.sv
// tb_sys_mem_arb
//   Directed scenarios followed by randomized traffic for sys_mem_arb,
//   checked every cycle against a queue-based reference model.
module tb_sys_mem_arb;

  localparam int NA   = 2;
  localparam int AW   = 27;
  localparam int DW   = 32;
  localparam int MAXP = 8;
  localparam int CW   = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NA-1:0] in_wr;
  logic [NA-1:0] in_rd;
  logic [AW-1:0] in_addr  [NA];
  logic [DW-1:0] in_wdata [NA];

  logic [NA*AW-1:0] agent_addr;
  logic [NA*DW-1:0] agent_wdata;
  logic [NA-1:0]    agent_wait;
  logic [NA-1:0]    agent_rd_valid;
  logic [DW-1:0]    agent_rdata;
  logic             rdy;
  logic             rdv;
  logic             cntrlr_wren;
  logic             cntrlr_rden;
  logic [AW-1:0]    cntrlr_addr;
  logic [DW-1:0]    cntrlr_wdata;
  logic [DW-1:0]    cntrlr_rdata;
  logic [CW-1:0]    rd_pend_cnt;
  logic             err_unexp_rd;

  assign agent_addr  = {in_addr[1], in_addr[0]};
  assign agent_wdata = {in_wdata[1], in_wdata[0]};

  always #5 clk = ~clk;

  sys_mem_arb #(
    .NUM_AGENTS (NA),
    .MEM_DATA_W (DW),
    .MEM_ADDR_W (AW),
    .MAX_RD_PEND(MAXP)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .agent_wren     (in_wr),
    .agent_rden     (in_rd),
    .agent_addr     (agent_addr),
    .agent_wdata    (agent_wdata),
    .agent_wait     (agent_wait),
    .agent_rd_valid (agent_rd_valid),
    .agent_rdata    (agent_rdata),
    .cntrlr_rdy     (rdy),
    .cntrlr_wren    (cntrlr_wren),
    .cntrlr_rden    (cntrlr_rden),
    .cntrlr_addr    (cntrlr_addr),
    .cntrlr_wdata   (cntrlr_wdata),
    .cntrlr_rd_valid(rdv),
    .cntrlr_rdata   (cntrlr_rdata),
    .rd_pend_cnt    (rd_pend_cnt),
    .err_unexp_rd   (err_unexp_rd)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  int            m_rr;
  int            pend[$];
  bit            m_cmd_v;
  bit            m_cmd_wr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [NA-1:0] m_rdv;
  logic [DW-1:0] m_rdata;
  bit            m_err;
  bit            m_acc;
  int            m_cand;
  logic [NA-1:0] obs_wait;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_rr     = 0;
    pend.delete();
    m_cmd_v  = 0;
    m_cmd_wr = 0;
    m_addr   = '0;
    m_wdata  = '0;
    m_rdv    = '0;
    m_rdata  = '0;
    m_err    = 0;
    m_acc    = 0;
    m_cand   = -1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_wr = '0;
    in_rd = '0;
    rdy   = 1'b1;
    rdv   = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // One clock: predict and check at negedge, advance model at posedge.
  task automatic cyc();
    logic [NA-1:0] ew;
    @(negedge clk);
    m_cand = -1;
    for (int k = 0; k < NA; k++) begin
      int idx;
      idx = (m_rr + k) % NA;
      if (m_cand < 0 && (in_wr[idx] || in_rd[idx])) m_cand = idx;
    end
    m_acc = 0;
    if (m_cand >= 0 && (!m_cmd_v || rdy))
      m_acc = in_wr[m_cand] || (pend.size() < MAXP);
    ew = '1;
    if (m_acc) ew[m_cand] = 1'b0;
    obs_wait = agent_wait;
    chk("agent_wait", 64'(agent_wait), 64'(ew));
    chk("cntrlr_wren", 64'(cntrlr_wren), 64'(m_cmd_v && m_cmd_wr));
    chk("cntrlr_rden", 64'(cntrlr_rden), 64'(m_cmd_v && !m_cmd_wr));
    if (m_cmd_v) chk("cntrlr_addr", 64'(cntrlr_addr), 64'(m_addr));
    if (m_cmd_v && m_cmd_wr) chk("cntrlr_wdata", 64'(cntrlr_wdata), 64'(m_wdata));
    chk("agent_rd_valid", 64'(agent_rd_valid), 64'(m_rdv));
    if (m_rdv != '0) chk("agent_rdata", 64'(agent_rdata), 64'(m_rdata));
    chk("rd_pend_cnt", 64'(rd_pend_cnt), 64'(pend.size()));
    chk("err_unexp_rd", 64'(err_unexp_rd), 64'(m_err));
    @(posedge clk);
    m_rdv = '0;
    if (rdv) begin
      if (pend.size() > 0) begin
        int t;
        t = pend.pop_front();
        m_rdv[t] = 1'b1;
        m_rdata  = cntrlr_rdata;
      end else begin
        m_err = 1;
      end
    end
    if (m_acc) begin
      m_cmd_v  = 1;
      m_cmd_wr = in_wr[m_cand];
      m_addr   = in_addr[m_cand];
      m_wdata  = in_wdata[m_cand];
      if (!in_wr[m_cand]) pend.push_back(m_cand);
      m_rr = (m_cand + 1) % NA;
    end else if (rdy) begin
      m_cmd_v = 0;
    end
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [AW-1:0] a0, a1, rec;
    logic [DW-1:0] d0, d1;
    a0 = 27'h0000100;
    a1 = 27'h0000200;
    d0 = 32'hD0D0_0000;
    d1 = 32'hD1D1_1111;
    in_addr[0]  = '0;
    in_addr[1]  = '0;
    in_wdata[0] = '0;
    in_wdata[1] = '0;
    cntrlr_rdata = '0;

    // Reset state
    do_reset();
    chk("rst_wren", 64'(cntrlr_wren), 64'(1'b0));
    chk("rst_rden", 64'(cntrlr_rden), 64'(1'b0));
    chk("rst_wait", 64'(agent_wait), 64'(2'b11));
    chk("rst_pend", 64'(rd_pend_cnt), 64'(0));
    chk("rst_err", 64'(err_unexp_rd), 64'(1'b0));
    chk("rst_rdv", 64'(agent_rd_valid), 64'(2'b00));

    // Contention: both agents write continuously
    in_addr[0] = a0; in_wdata[0] = 32'hAAAA_0000;
    in_addr[1] = a1; in_wdata[1] = 32'hBBBB_1111;
    in_wr = 2'b11;
    for (int k = 0; k < 6; k++) begin
      cyc();
      chk("cont_wait", 64'(obs_wait), (k % 2 == 0) ? 64'(2'b10) : 64'(2'b01));
      chk("cont_addr", 64'(cntrlr_addr), (k % 2 == 0) ? 64'(a0) : 64'(a1));
      chk("cont_wren", 64'(cntrlr_wren), 64'(1'b1));
    end

    // Backpressure: queued write from agent1 held for 5 cycles
    rdy = 1'b0;
    rec = cntrlr_addr;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("bp_wait", 64'(obs_wait), 64'(2'b11));
      chk("bp_addr", 64'(cntrlr_addr), 64'(rec));
      chk("bp_wren", 64'(cntrlr_wren), 64'(1'b1));
    end
    rdy = 1'b1;
    cyc();
    chk("bp_rel_wait", 64'(obs_wait), 64'(2'b10));
    chk("bp_rel_addr", 64'(cntrlr_addr), 64'(a0));
    in_wr = 2'b00;

    // Read tagging
    do_reset();
    chk("tag_pend0", 64'(rd_pend_cnt), 64'(0));
    in_addr[1] = a1; in_rd = 2'b10;
    cyc();
    chk("tag_wait1", 64'(obs_wait), 64'(2'b01));
    chk("tag_addr1", 64'(cntrlr_addr), 64'(a1));
    chk("tag_pend1", 64'(rd_pend_cnt), 64'(1));
    in_addr[0] = a0; in_rd = 2'b01;
    cyc();
    chk("tag_wait0", 64'(obs_wait), 64'(2'b10));
    chk("tag_addr0", 64'(cntrlr_addr), 64'(a0));
    chk("tag_pend2", 64'(rd_pend_cnt), 64'(2));
    in_rd = 2'b00;
    rdv = 1'b1; cntrlr_rdata = d1;
    cyc();
    chk("tag_pend3", 64'(rd_pend_cnt), 64'(1));
    chk("tag_rdv1", 64'(agent_rd_valid), 64'(2'b10));
    chk("tag_dat1", 64'(agent_rdata), 64'(d1));
    cntrlr_rdata = d0;
    cyc();
    chk("tag_pend4", 64'(rd_pend_cnt), 64'(0));
    chk("tag_rdv0", 64'(agent_rd_valid), 64'(2'b01));
    chk("tag_dat0", 64'(agent_rdata), 64'(d0));
    rdv = 1'b0;
    cyc();
    chk("tag_rdv_end", 64'(agent_rd_valid), 64'(2'b00));

    // FIFO full
    do_reset();
    in_addr[0] = 27'h0000040; in_rd = 2'b01;
    repeat (MAXP) cyc();
    chk("full_pend", 64'(rd_pend_cnt), 64'(MAXP));
    in_addr[1] = 27'h0000080; in_wdata[1] = 32'h1234_5678; in_wr = 2'b10;
    cyc();
    chk("full_wr_wait", 64'(obs_wait), 64'(2'b01));
    chk("full_wr_cmd", 64'(cntrlr_wren), 64'(1'b1));
    in_wr = 2'b00;
    cyc();
    chk("full_blk1", 64'(obs_wait), 64'(2'b11));
    cyc();
    chk("full_blk2", 64'(obs_wait), 64'(2'b11));
    rdv = 1'b1; cntrlr_rdata = 32'hCAFE_0001;
    cyc();
    chk("full_popcyc", 64'(obs_wait), 64'(2'b11));
    rdv = 1'b0;
    cyc();
    chk("full_acc", 64'(obs_wait), 64'(2'b10));
    chk("full_pend2", 64'(rd_pend_cnt), 64'(MAXP));
    in_rd = 2'b00;

    // Unexpected read data and reset mid-operation
    do_reset();
    rdv = 1'b1;
    cyc();
    rdv = 1'b0;
    chk("err_set", 64'(err_unexp_rd), 64'(1'b1));
    chk("err_nostrobe", 64'(agent_rd_valid), 64'(2'b00));
    chk("err_nounder", 64'(rd_pend_cnt), 64'(0));
    in_rd = 2'b01;
    repeat (3) cyc();
    in_rd = 2'b00;
    chk("err_pend3", 64'(rd_pend_cnt), 64'(3));
    rst_n = 1'b0;
    #1;
    chk("arst_pend", 64'(rd_pend_cnt), 64'(0));
    chk("arst_err", 64'(err_unexp_rd), 64'(1'b0));
    chk("arst_rden", 64'(cntrlr_rden), 64'(1'b0));
    do_reset();
    rdv = 1'b1;
    cyc();
    rdv = 1'b0;
    chk("late_err", 64'(err_unexp_rd), 64'(1'b1));
    chk("late_nostrobe", 64'(agent_rd_valid), 64'(2'b00));

    // Randomized traffic
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NA; i++) begin
        if (m_acc && m_cand == i) begin
          in_wr[i] = 1'b0;
          in_rd[i] = 1'b0;
        end
        if (!in_wr[i] && !in_rd[i] && $urandom_range(2) != 0) begin
          case ($urandom_range(3))
            0:       in_wr[i] = 1'b1;
            1, 2:    in_rd[i] = 1'b1;
            default: begin in_wr[i] = 1'b1; in_rd[i] = 1'b1; end
          endcase
          in_addr[i]  = AW'($urandom);
          in_wdata[i] = $urandom;
        end
      end
      rdy = ($urandom_range(3) != 0);
      rdv = (pend.size() > 0) && ($urandom_range(2) == 0);
      cntrlr_rdata = $urandom;
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
